input_debouncer: RTL and testbench
==================================

# input_debouncer

Front-end conditioning stage for the board's mechanical inputs. It synchronizes the six raw push-buttons and eight slide switches into the `clk` domain and debounces each one with a per-channel stability counter. It feeds clean, still active-low values into the input-combining stage that builds the processor's 46-bit INPUT word. It also emits one-cycle button-press pulses for blocks that need edge events rather than levels.

## Interface

- `NUM_BUTTONS`, default 6: number of button channels.
- `NUM_SWITCHES`, default 8: number of switch channels.
- `DEBOUNCE_CYCLES`, default 320000 (10 ms at 32 MHz): consecutive stable cycles required before a change is accepted. Must be ≥ 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width; derived, not overridden.

Ports:

- `clk` input 1: system clock; single clock domain.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `buttons_raw` input NUM_BUTTONS: raw pad inputs, asynchronous, active-low (0 = pressed).
- `switches_raw` input NUM_SWITCHES: raw pad inputs, asynchronous, active-low (0 = on).
- `buttons_db` output NUM_BUTTONS: debounced buttons, active-low, registered.
- `switches_db` output NUM_SWITCHES: debounced switches, active-low, registered.
- `btn_press` output NUM_BUTTONS: one-cycle pulse per button on debounced press (1→0 transition of `buttons_db`).

## Operation

- All 14 channels are identical. Each channel has a 2-FF synchronizer (`s1`, `s2`), a counter `cnt[CNT_W-1:0]` and a debounced state `db`.
- Reset (`rst_n`=0, async) forces the following, regardless of clock:
  - `s1`, `s2`, `db` to 1 (released/off).
  - `cnt` to 0.
  - `btn_press` to 0.
- Per cycle, channel behaviour:
  - `s2 == db`: `cnt` ← 0; `db` holds.
  - `s2 != db` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` ← `cnt`+1.
  - `s2 != db` and `cnt == DEBOUNCE_CYCLES-1`: `db` ← `s2`; `cnt` ← 0.
- Any bounce back to the `db` value before acceptance clears `cnt`. Acceptance therefore needs DEBOUNCE_CYCLES consecutive differing samples of `s2`.
- `btn_press[i]` is registered: it is 1 in exactly the cycle where `buttons_db[i]` first reads 0 after having been 1. Otherwise it is 0.
- Switches produce no pulses.
- Release (0→1) of a button produces no pulse.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Output polarity is unchanged from the raw inputs; inversion stays downstream.

## Timing

- Raw edge sampled by `s1` at edge k. `s2` follows at k+1.
- `db` changes at edge k+1+DEBOUNCE_CYCLES if the input stays stable. `btn_press` is high in the cycle following that edge.
- With DEBOUNCE_CYCLES=1, `db` follows `s2` one cycle later. Total raw-to-output latency is 3 edges.
- Channels are independent. Simultaneous changes on several channels resolve in the same cycle with no priority.
- Reset mid-count discards the pending change. After release, a still-asserted input needs the full 2+DEBOUNCE_CYCLES again.
- No combinational path from any input to any output.

## Structure

- Shared header `consolite_io.vh` holds:
  - `NUM_BUTTONS` and `NUM_SWITCHES`, also used by the input-combining stage.
  - `BOARD_CLK_HZ`.
  - `DEBOUNCE_MS`; DEBOUNCE_CYCLES is computed from `BOARD_CLK_HZ` and `DEBOUNCE_MS`.
- One sub-module, `debounce_channel`, with parameters `DEBOUNCE_CYCLES`/`CNT_W` and ports `clk`, `rst_n`, `raw`, `db`, `fall`. It is instantiated NUM_BUTTONS+NUM_SWITCHES times via generate. The top level only concatenates and routes the `fall` outputs of button channels to `btn_press`.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

- **Reset values:** hold `rst_n`=0 with raw=0 on all channels → `buttons_db`=6'h3F, `switches_db`=8'hFF, `btn_press`=0. After release with raw=0 held, outputs go to 0 at edge 6, and `btn_press`=6'h3F for exactly one cycle.
- **Clean press:** drive `buttons_raw[2]` 1→0 at edge k and hold → `buttons_db[2]`=0 from edge k+5 and `btn_press`=6'b000100 for one cycle. Releasing later produces no pulse; `buttons_db[2]` returns to 1 five edges after the release.
- **Bounce rejection:** toggle `switches_raw[0]` 1,0,0,0,1,0,0,0,0 on successive cycles → no change until four consecutive 0s reach `s2`. `switches_db[0]` falls at the edge after the fourth consecutive 0 sample.
- **Simultaneous events:** change `buttons_raw`=6'h3E and `switches_raw`=8'h7F on the same edge → both outputs update on the same edge, with `btn_press`=6'h01.
- **Reset mid-count:** start a press, then assert `rst_n` asynchronously after 2 counted cycles → outputs immediately all-ones and `cnt` 0. Press then completes the full 6-edge latency after reset release.
- **Edge case, DEBOUNCE_CYCLES=1 build:** a single-cycle raw pulse 1→0→1 → `db` follows with 3-edge latency and `btn_press` pulses once.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Board-level input constants shared by the debouncer and the input-combining stage.
// The debounce window is derived from the board clock and a millisecond setting.
package input_debouncer_pkg;

  localparam int unsigned NumButtons  = 6;
  localparam int unsigned NumSwitches = 8;

  localparam int unsigned BoardClkHz     = 32_000_000;
  localparam int unsigned DebounceMs     = 10;
  localparam int unsigned DebounceCycles = (BoardClkHz / 1000) * DebounceMs;

  // Width that holds 0..cycles without wrapping.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Raw pad inputs and their conditioned, still active-low outputs.
// The master side drives the pads; the slave side is the debouncer.
interface input_debouncer_if
  import input_debouncer_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS  = NumButtons,
  parameter int unsigned NUM_SWITCHES = NumSwitches
);

  logic [NUM_BUTTONS-1:0]  buttons_raw;
  logic [NUM_SWITCHES-1:0] switches_raw;
  logic [NUM_BUTTONS-1:0]  buttons_db;
  logic [NUM_SWITCHES-1:0] switches_db;
  logic [NUM_BUTTONS-1:0]  btn_press;

  modport master (
    output buttons_raw,
    output switches_raw,
    input  buttons_db,
    input  switches_db,
    input  btn_press
  );

  modport slave (
    input  buttons_raw,
    input  switches_raw,
    output buttons_db,
    output switches_db,
    output btn_press
  );

endinterface

// File: rtl/debounce_channel.sv
// One input channel: 2-FF synchronizer, stability counter and registered debounced level,
// plus a one-cycle pulse when the debounced level falls (press).
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCycles,
  parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic fall
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = '0;
    db_d   = db_q;
    fall_d = 1'b0;
    if (s2_q != db_q) begin
      if (cnt_q >= CntMax) begin
        db_d   = s2_q;
        // Only a 1->0 acceptance is a press.
        fall_d = db_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      db_q   <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
    end
  end

  assign db   = db_q;
  assign fall = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces all button and switch pads with identical channels; button channels also
// provide press pulses. Outputs keep the pads' active-low polarity.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = NumButtons,
  parameter int unsigned NUM_SWITCHES    = NumSwitches,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCycles,
  parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input logic              clk,
  input logic              rst_n,
  input_debouncer_if.slave io
);

  // Switches never need edge events.
  logic [NUM_SWITCHES-1:0] unused_sw_fall;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (io.buttons_raw[i]),
      .db   (io.buttons_db[i]),
      .fall (io.btn_press[i])
    );
  end

  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (io.switches_raw[i]),
      .db   (io.switches_db[i]),
      .fall (unused_sw_fall[i])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: a 4-cycle build and a 1-cycle build share the same pads and
// are compared every cycle against a sample-history model, plus directed latency checks.
module tb_input_debouncer;

  logic       clk;
  logic       rst_n;
  logic [5:0] braw;
  logic [7:0] sraw;
  int         n_tests;
  int         n_fail;

  input_debouncer_if #(.NUM_BUTTONS(6), .NUM_SWITCHES(8)) if4 ();
  input_debouncer_if #(.NUM_BUTTONS(6), .NUM_SWITCHES(8)) if1 ();

  assign if4.buttons_raw  = braw;
  assign if4.switches_raw = sraw;
  assign if1.buttons_raw  = braw;
  assign if1.switches_raw = sraw;

  input_debouncer #(.NUM_BUTTONS(6), .NUM_SWITCHES(8), .DEBOUNCE_CYCLES(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (if4.slave)
  );

  input_debouncer #(.NUM_BUTTONS(6), .NUM_SWITCHES(8), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: h[c] bit i is the pad value sampled i+1 edges ago. At an edge, the synchronized
  // values in play are those sampled 2..DC+1 edges back (old bits 1..DC); if all differ
  // from the debounced level, it flips. Reset fills the history with released samples.
  logic [13:0] raw_all;
  logic [5:0]  h4 [14];
  logic [5:0]  h1 [14];
  logic [13:0] md4, md1;
  logic [5:0]  mp4, mp1;

  assign raw_all = {sraw, braw};

  function automatic logic run_differs(input logic [5:0] h, input logic d, input int dc);
    for (int i = 1; i <= dc; i++) begin
      if (h[i] == d) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 14; c++) begin
        h4[c] <= '1;
        h1[c] <= '1;
      end
      md4 <= '1;
      md1 <= '1;
      mp4 <= '0;
      mp1 <= '0;
    end else begin
      mp4 <= '0;
      mp1 <= '0;
      for (int c = 0; c < 14; c++) begin
        h4[c] <= {h4[c][4:0], raw_all[c]};
        h1[c] <= {h1[c][4:0], raw_all[c]};
        if (run_differs(h4[c], md4[c], 4)) begin
          md4[c] <= ~md4[c];
          if (c < 6 && md4[c]) mp4[c] <= 1'b1;
        end
        if (run_differs(h1[c], md1[c], 1)) begin
          md1[c] <= ~md1[c];
          if (c < 6 && md1[c]) mp1[c] <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("dc4_btn_db", 32'(if4.buttons_db), 32'(md4[5:0]));
    check("dc4_sw_db", 32'(if4.switches_db), 32'(md4[13:6]));
    check("dc4_press", 32'(if4.btn_press), 32'(mp4));
    check("dc1_btn_db", 32'(if1.buttons_db), 32'(md1[5:0]));
    check("dc1_sw_db", 32'(if1.switches_db), 32'(md1[13:6]));
    check("dc1_press", 32'(if1.btn_press), 32'(mp1));
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic settle();
    braw = '1;
    sraw = '1;
    repeat (10) cycle();
  endtask

  int n;
  int pulses;
  bit found;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    braw    = '0;
    sraw    = '0;

    // Reset values with all pads asserted, then release.
    repeat (3) cycle();
    check("rst_btn_db", 32'(if4.buttons_db), 32'h3F);
    check("rst_sw_db", 32'(if4.switches_db), 32'hFF);
    check("rst_press", 32'(if4.btn_press), 32'h0);
    rst_n = 1'b1;
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (!found && if4.buttons_db == 6'h00) begin
        found = 1'b1;
        n = i;
        check("rel_press", 32'(if4.btn_press), 32'h3F);
        check("rel_sw_db", 32'(if4.switches_db), 32'h00);
      end
    end
    check("rel_latency", 32'(n), 32'd6);
    settle();

    // Clean press of button 2, then release with no pulse.
    braw[2] = 1'b0;
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (!found && !if4.buttons_db[2]) begin
        found = 1'b1;
        n = i;
        check("press_pulse", 32'(if4.btn_press), 32'h04);
      end
    end
    check("press_latency", 32'(n), 32'd6);
    braw[2] = 1'b1;
    n = 0;
    found = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (if4.btn_press != '0) pulses++;
      if (!found && if4.buttons_db[2]) begin
        found = 1'b1;
        n = i;
      end
    end
    check("release_latency", 32'(n), 32'd6);
    check("release_pulses", 32'(pulses), 32'd0);
    settle();

    // Bounce on switch 0: only the final run of four zeros is accepted.
    begin
      logic [8:0] seq;
      seq = 9'b000010001; // bit i = value driven before edge k+i
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
        sraw[0] = seq[i];
        cycle();
        if (!if4.switches_db[0]) pulses++;
      end
      check("bounce_early", 32'(pulses), 32'd0);
      cycle();
      check("bounce_hold", 32'(if4.switches_db[0]), 32'd1);
      cycle();
      check("bounce_accept", 32'(if4.switches_db[0]), 32'd0);
    end
    settle();

    // Simultaneous button and switch change.
    braw = 6'h3E;
    sraw = 8'h7F;
    repeat (5) cycle();
    check("simul_before_btn", 32'(if4.buttons_db), 32'h3F);
    check("simul_before_sw", 32'(if4.switches_db), 32'hFF);
    cycle();
    check("simul_btn", 32'(if4.buttons_db), 32'h3E);
    check("simul_sw", 32'(if4.switches_db), 32'h7F);
    check("simul_press", 32'(if4.btn_press), 32'h01);
    settle();

    // Reset in the middle of a count discards the pending press.
    braw[1] = 1'b0;
    repeat (4) cycle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_btn", 32'(if4.buttons_db), 32'h3F);
    check("midrst_sw", 32'(if4.switches_db), 32'hFF);
    check("midrst_press", 32'(if4.btn_press), 32'h0);
    cycle();
    rst_n = 1'b1;
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (!found && !if4.buttons_db[1]) begin
        found = 1'b1;
        n = i;
      end
    end
    check("midrst_latency", 32'(n), 32'd6);
    settle();

    // Single-cycle pulse on button 3: the 1-cycle build follows, the 4-cycle one does not.
    braw[3] = 1'b0;
    cycle();
    braw[3] = 1'b1;
    pulses = 0;
    n = 0;
    for (int i = 2; i <= 9; i++) begin
      cycle();
      if (if1.btn_press != '0) pulses++;
      if (n == 0 && !if1.buttons_db[3]) n = i;
      check("dc1_pulse_dc4_db", 32'(if4.buttons_db), 32'h3F);
    end
    check("dc1_latency", 32'(n), 32'd3);
    check("dc1_pulses", 32'(pulses), 32'd1);
    settle();

    // Randomized pads with occasional asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      int unsigned odds;
      odds = (i < 1000) ? 3 : 9;
      for (int b = 0; b < 6; b++) if ($urandom_range(odds) == 0) braw[b] = ~braw[b];
      for (int s = 0; s < 8; s++) if ($urandom_range(odds) == 0) sraw[s] = ~sraw[s];
      cycle();
      if ($urandom_range(199) == 0) begin
        #2 rst_n = 1'b0;
        #1 compare_all();
        #1 rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
